tile_skew_feeder: RTL and testbench

- Sits directly downstream of the tile FIFO that the tile accumulator writes packed 16-lane activation tiles into.
- Pops tiles from that FIFO and unpacks each into LANES lanes.
- Applies the triangular input skew the systolic array's west edge needs: lane i is delayed i cycles.
- Streams a job of num_input_tiles tiles, then drains the skew pipeline and pulses done.

---
 rtl/tile_skew_feeder.sv | 126 ++++++++++++
 tb/tb_tile_skew_feeder.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tile_skew_feeder.sv
// Pops packed activation tiles from the upstream FIFO and feeds them to the systolic
// array west edge with a triangular skew (lane i delayed i cycles). Optional: TILE_FEEDER_STATS_EN.
module tile_skew_feeder #(
  parameter int WIDTH           = 16,
  parameter int LANES           = 16,
  parameter int MAX_INPUT_TILES = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [3:0]             num_input_tiles,
  input  logic                   fifo_empty,
  input  logic [WIDTH*LANES-1:0] fifo_tile,
  output logic                   fifo_read,
  output logic [WIDTH*LANES-1:0] act_out,
  output logic [LANES-1:0]       act_valid,
`ifdef TILE_FEEDER_STATS_EN
  output logic [15:0]            stall_count,
`endif
  output logic                   busy,
  output logic                   done,
  output logic                   err
);

  typedef enum logic [1:0] {IDLE, STREAM, DRAIN, DONE} state_t;

  localparam int              DRN_W    = $clog2(LANES + 1);
  localparam logic [3:0]      MAX_T    = 4'(MAX_INPUT_TILES);
  localparam logic [DRN_W-1:0] DRN_INIT = DRN_W'(LANES - 1);

  state_t           state, state_n;
  logic [3:0]       rem, rem_n;
  logic [DRN_W-1:0] drn, drn_n;
  logic             err_n;
  logic             legal;

  assign legal = (num_input_tiles != 4'd0) && (num_input_tiles <= MAX_T);
  assign busy  = (state == STREAM) || (state == DRAIN);
  assign done  = (state == DONE);

  always_comb begin
    state_n   = state;
    rem_n     = rem;
    drn_n     = drn;
    err_n     = 1'b0;
    fifo_read = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          if (legal) begin
            rem_n   = num_input_tiles;
            state_n = STREAM;
          end else begin
            err_n = 1'b1;
          end
        end
      end
      STREAM: begin
        fifo_read = !fifo_empty && (rem != 4'd0);
        if (fifo_read) begin
          rem_n = rem - 4'd1;
          if (rem == 4'd1) begin
            state_n = DRAIN;
            drn_n   = DRN_INIT;
          end
        end
      end
      DRAIN: begin
        if (drn == '0) state_n = DONE;
        else           drn_n   = drn - DRN_W'(1);
      end
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      rem   <= '0;
      drn   <= '0;
      err   <= 1'b0;
    end else begin
      state <= state_n;
      rem   <= rem_n;
      drn   <= drn_n;
      err   <= err_n;
    end
  end

`ifdef TILE_FEEDER_STATS_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_count <= '0;
    end else if ((state == IDLE) && start && legal) begin
      stall_count <= '0;
    end else if ((state == STREAM) && fifo_empty && (rem != 4'd0) && (stall_count != 16'hFFFF)) begin
      stall_count <= stall_count + 16'd1;
    end
  end
`endif

  // Skew pipe: lane i is an (i+1)-deep shift register; bubbles shift zeros so no stale data escapes.
  for (genvar i = 0; i < LANES; i++) begin : g_lane
    logic [WIDTH-1:0] skew_p [0:i];
    logic [i:0]       vld_p;

    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        for (int k = 0; k <= i; k++) skew_p[k] <= '0;
        vld_p <= '0;
      end else begin
        skew_p[0] <= fifo_read ? fifo_tile[WIDTH*(LANES-i)-1 -: WIDTH] : '0;
        vld_p[0]  <= fifo_read;
        for (int k = 1; k <= i; k++) begin
          skew_p[k] <= skew_p[k-1];
          vld_p[k]  <= vld_p[k-1];
        end
      end
    end

    assign act_out[WIDTH*(LANES-i)-1 -: WIDTH] = skew_p[i];
    assign act_valid[i]                        = vld_p[i];
  end

endmodule

// File: tb/tb_tile_skew_feeder.sv
// Scoreboard bench for tile_skew_feeder: a FIFO model feeds tiles, a cycle-stamped lane model
// predicts every act_out/act_valid/busy/done/err/fifo_read value.
module tb_tile_skew_feeder;

  localparam int W  = 16;
  localparam int L  = 16;
  localparam int TW = W * L;

  typedef struct {
    int          lane;
    logic [W-1:0] v;
    int          c;
  } ent_t;

  logic          clk;
  logic          reset;
  logic          start;
  logic [3:0]    num_input_tiles;
  logic          fifo_empty;
  logic [TW-1:0] fifo_tile;
  logic          fifo_read;
  logic [TW-1:0] act_out;
  logic [L-1:0]  act_valid;
  logic          busy;
  logic          done;
  logic          err;
`ifdef TILE_FEEDER_STATS_EN
  logic [15:0]   stall_count;
`endif

  tile_skew_feeder #(.WIDTH(W), .LANES(L), .MAX_INPUT_TILES(4)) dut (
    .clk             (clk),
    .reset           (reset),
    .start           (start),
    .num_input_tiles (num_input_tiles),
    .fifo_empty      (fifo_empty),
    .fifo_tile       (fifo_tile),
    .fifo_read       (fifo_read),
    .act_out         (act_out),
    .act_valid       (act_valid),
`ifdef TILE_FEEDER_STATS_EN
    .stall_count     (stall_count),
`endif
    .busy            (busy),
    .done            (done),
    .err             (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  // FIFO model
  logic [TW-1:0] tile_q[$];
  logic          gate     = 1'b0;
  int            gate_pct = 0;

  // Reference model state
  ent_t        exq[$];
  ent_t        keep[$];
  int          done_q[$];
  int          err_q[$];
  logic        act        = 1'b0;
  int          busy_from  = 0;
  int          busy_until = -1;
  int          model_rem  = 0;
  logic [15:0] stall_exp  = '0;
  logic        mon_en     = 1'b0;

  logic [TW-1:0] eo;
  logic [L-1:0]  ev;
  logic          stream_m, erd, ebusy, edone, eerr;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic chk(input string name, input logic [TW-1:0] got, input logic [TW-1:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s @cyc %0d: got %0h, expected %0h", name, cyc, got, exp);
    end
  endtask

  function automatic logic [W-1:0] lane_of(input logic [TW-1:0] t, input int i);
    return t[W*(L-i)-1 -: W];
  endfunction

  task automatic set_fifo();
    fifo_empty = (tile_q.size() == 0) || gate;
    fifo_tile  = (tile_q.size() != 0) ? tile_q[0] : '0;
  endtask

  task automatic tick();
    logic rd;
    @(negedge clk);
    rd = fifo_read;
    @(posedge clk);
    #1;
    start = 1'b0;
    if (rd && tile_q.size() > 0) void'(tile_q.pop_front());
    gate = (gate_pct > 0) && ($urandom_range(99) < gate_pct);
    set_fifo();
  endtask

  task automatic issue_start(input int n, input bit accept);
    start           = 1'b1;
    num_input_tiles = 4'(n);
    if (accept) begin
      act        = 1'b1;
      busy_from  = cyc + 1;
      busy_until = -1;
      model_rem  = n;
      stall_exp  = '0;
    end else if (n == 0 || n > 4) begin
      err_q.push_back(cyc + 1);
    end
    tick();
  endtask

  task automatic wait_idle(input string name);
    int k = 0;
    while ((act || done_q.size() > 0 || exq.size() > 0 || err_q.size() > 0) && k < 400) begin
      tick();
      k++;
    end
    n_tests++;
    if (k >= 400) begin
      n_fail++;
      $display("FAIL %s_timeout: job still pending after %0d cycles, expected to finish", name, k);
    end
  endtask

  task automatic check_stall(input string name);
`ifdef TILE_FEEDER_STATS_EN
    chk(name, TW'(stall_count), TW'(stall_exp));
`endif
  endtask

  // Monitor: compare every output each cycle against the model, then advance the model.
  initial forever begin
    @(negedge clk);
    if (mon_en) begin
      stream_m = act && (cyc >= busy_from) && (model_rem > 0);
      erd      = stream_m && !fifo_empty;
      ebusy    = act && (cyc >= busy_from) && (busy_until < 0 || cyc <= busy_until);
      edone    = (done_q.size() > 0) && (done_q[0] == cyc);
      eerr     = (err_q.size() > 0) && (err_q[0] == cyc);
      eo = '0;
      ev = '0;
      keep.delete();
      foreach (exq[k]) begin
        if (exq[k].c == cyc) begin
          ev[exq[k].lane] = 1'b1;
          eo[W*(L-exq[k].lane)-1 -: W] = exq[k].v;
        end else begin
          keep.push_back(exq[k]);
        end
      end
      exq = keep;
      chk("fifo_read", TW'(fifo_read), TW'(erd));
      chk("busy", TW'(busy), TW'(ebusy));
      chk("done", TW'(done), TW'(edone));
      chk("err", TW'(err), TW'(eerr));
      chk("act_valid", TW'(act_valid), TW'(ev));
      chk("act_out", act_out, eo);
      if (stream_m && fifo_empty && stall_exp != 16'hFFFF) stall_exp++;
      if (edone) begin
        void'(done_q.pop_front());
        act = 1'b0;
      end
      if (eerr) void'(err_q.pop_front());
      if (erd) begin
        for (int l = 0; l < L; l++) begin
          ent_t e;
          e.lane = l;
          e.v    = lane_of(fifo_tile, l);
          e.c    = cyc + 1 + l;
          exq.push_back(e);
        end
        model_rem--;
        if (model_rem == 0) begin
          busy_until = cyc + L;
          done_q.push_back(cyc + L + 1);
        end
      end
    end
  end

  task automatic model_reset();
    exq.delete();
    done_q.delete();
    err_q.delete();
    act       = 1'b0;
    model_rem = 0;
    stall_exp = '0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [TW-1:0] t;
    reset           = 1'b1;
    start           = 1'b0;
    num_input_tiles = '0;
    fifo_empty      = 1'b1;
    fifo_tile       = '0;
    #2 reset = 1'b0;
    #1;
    chk("reset_act_out", act_out, '0);
    chk("reset_act_valid", TW'(act_valid), '0);
    chk("reset_busy", TW'(busy), '0);
    chk("reset_done", TW'(done), '0);
    chk("reset_err", TW'(err), '0);
    chk("reset_fifo_read", TW'(fifo_read), '0);
    check_stall("reset_stall");
    mon_en = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    tick();

    // Single tile, lanes 0x0001..0x0010
    for (int i = 0; i < L; i++) t[W*(L-i)-1 -: W] = W'(i + 1);
    tile_q.push_back(t);
    set_fifo();
    issue_start(1, 1'b1);
    wait_idle("single");

    // Back-to-back four tiles, all lanes 0xA0+k
    for (int k = 0; k < 4; k++) tile_q.push_back({L{W'(16'h00A0 + k)}});
    set_fifo();
    issue_start(4, 1'b1);
    wait_idle("b2b");
    check_stall("b2b_stall");

    // Bubble: three empty cycles between two tiles
    tile_q.push_back({L{16'h1111}});
    set_fifo();
    issue_start(2, 1'b1);
    for (int k = 0; k < 20 && tile_q.size() > 0; k++) tick();
    repeat (3) tick();
    tile_q.push_back({L{16'h2222}});
    set_fifo();
    wait_idle("bubble");
`ifdef TILE_FEEDER_STATS_EN
    chk("bubble_stall", TW'(stall_count), TW'(16'd3));
`endif

    // Illegal counts
    issue_start(0, 1'b0);
    tick();
    issue_start(5, 1'b0);
    repeat (3) tick();
    wait_idle("illegal");

    // Reset mid-stream with tiles still waiting in the FIFO
    tile_q.push_back({L{16'h3333}});
    tile_q.push_back({L{16'h4444}});
    set_fifo();
    issue_start(4, 1'b1);
    repeat (4) tick();
    tile_q.push_back({L{16'h5555}});
    tile_q.push_back({L{16'h6666}});
    set_fifo();
    reset = 1'b0;
    model_reset();
    #1;
    chk("midrst_act_out", act_out, '0);
    chk("midrst_act_valid", TW'(act_valid), '0);
    chk("midrst_busy", TW'(busy), '0);
    check_stall("midrst_stall");
    repeat (2) tick();
    reset = 1'b1;
    repeat (3) tick();
    tile_q.delete();
    tile_q.push_back({L{16'h7777}});
    set_fifo();
    issue_start(1, 1'b1);
    wait_idle("after_reset");

    // Start during DRAIN must be ignored
    tile_q.push_back({L{16'h8888}});
    set_fifo();
    issue_start(1, 1'b1);
    repeat (5) tick();
    issue_start(3, 1'b0);
    wait_idle("start_busy");
    repeat (4) tick();

    // Randomized jobs with random FIFO stalls
    gate_pct = 30;
    for (int j = 0; j < 25; j++) begin
      int n;
      n = $urandom_range(4, 1);
      for (int k = 0; k < n; k++) begin
        for (int w = 0; w < TW / 32; w++) t[w*32 +: 32] = $urandom();
        tile_q.push_back(t);
      end
      set_fifo();
      issue_start(n, 1'b1);
      wait_idle("random");
      check_stall("random_stall");
    end
    gate_pct = 0;
    repeat (5) tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
